// File: rtl/sel_decoder_seq.sv
//------------------------------------------------------------------------------
// sel_decoder_seq
//
// Registered, parametrised N-to-2^N one-hot decoder with a load handshake and
// an auto-scan mode. Either holds a loaded select index on its one-hot output
// or steps through all 2^N outputs, keeping each one active for DWELL enabled
// cycles.
//
// Parameters:
//   N      select width, legal 1..8; output width is 2^N
//   DWELL  enabled cycles per index in scan mode, legal >= 1
//
// Ports:
//   i_clk          clock, all state updates on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_en           output enable; 0 blanks o_out and freezes scan progress
//   i_mode         sampled on load accept: 0 = hold, 1 = scan
//   i_load_valid   load request
//   i_load_sel     select value / scan start index
//   o_load_ready   block can accept a load (IDLE or HOLD)
//   i_stop         abort scan / clear hold, return to IDLE
//   o_out          registered one-hot output
//   o_sel          current select index
//   o_wrap         one-cycle pulse when scan steps from 2^N-1 to 0
//
// Build option:
//   SEL_DECODER_ACTIVE_LOW_EN  when defined, o_out is one-cold: the active bit
//                              is 0 and the inactive value is all ones. o_sel,
//                              o_wrap and o_load_ready are unaffected.
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no output driven, waiting for a load
//   ST_HOLD | drive one-hot(o_sel) while i_en, accept replacement loads
//   ST_SCAN | step o_sel every DWELL enabled cycles, loads refused
//------------------------------------------------------------------------------
module sel_decoder_seq #(
    parameter int N     = 3,
    parameter int DWELL = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic                 i_load_valid,
    input  logic [N-1:0]         i_load_sel,
    output logic                 o_load_ready,
    input  logic                 i_stop,
    output logic [(1<<N)-1:0]    o_out,
    output logic [N-1:0]         o_sel,
    output logic                 o_wrap
);

    localparam int M  = 1 << N;
    // Keep at least one counter bit so DWELL=1 still has a legal vector.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  SEL_LAST = {N{1'b1}};

`ifdef SEL_DECODER_ACTIVE_LOW_EN
    localparam logic [M-1:0] OUT_IDLE = {M{1'b1}};
`else
    localparam logic [M-1:0] OUT_IDLE = {M{1'b0}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_sel;
    logic [CW-1:0]   r_cnt;
    logic            r_wrap;
    logic [M-1:0]    r_out;

    state_t          w_nxt_state;
    logic [N-1:0]    w_nxt_sel;
    logic [CW-1:0]   w_nxt_cnt;
    logic            w_nxt_wrap;
    logic [M-1:0]    w_nxt_out;
    logic [M-1:0]    w_hot;
    logic            w_drive;
    logic            w_load_ready;
    logic            w_load_acc;

    // Ready depends only on the state register, so it has no input path.
    assign w_load_ready = (r_state != ST_SCAN);
    // Stop wins over a simultaneous load.
    assign w_load_acc   = i_load_valid & w_load_ready & ~i_stop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
            r_out   <= OUT_IDLE;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_cnt   <= w_nxt_cnt;
            r_wrap  <= w_nxt_wrap;
            r_out   <= w_nxt_out;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_cnt   = r_cnt;
        w_nxt_wrap  = 1'b0;

        if (i_stop) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
        end else if (w_load_acc) begin
            w_nxt_sel   = i_load_sel;
            w_nxt_cnt   = '0;
            w_nxt_state = i_mode ? ST_SCAN : ST_HOLD;
        end else begin
            case (r_state)
                ST_IDLE: w_nxt_state = ST_IDLE;
                ST_HOLD: w_nxt_state = ST_HOLD;
                ST_SCAN: begin
                    if (i_en) begin
                        if (r_cnt == CNT_LAST) begin
                            w_nxt_cnt  = '0;
                            w_nxt_sel  = r_sel + N'(1);
                            // Registered alongside sel, so it is high in the
                            // first cycle that shows index 0.
                            w_nxt_wrap = (r_sel == SEL_LAST);
                        end else begin
                            w_nxt_cnt  = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end
            endcase
        end

        // Output is decoded from the next-state values so it lines up with
        // o_sel after the same edge; a single index write keeps it one-hot.
        w_drive = (w_nxt_state != ST_IDLE) && i_en;
        w_hot   = '0;
        if (w_drive) begin
            w_hot[w_nxt_sel] = 1'b1;
        end
`ifdef SEL_DECODER_ACTIVE_LOW_EN
        w_nxt_out = ~w_hot;
`else
        w_nxt_out = w_hot;
`endif
    end

    assign o_load_ready = w_load_ready;
    assign o_out        = r_out;
    assign o_sel        = r_sel;
    assign o_wrap       = r_wrap;

endmodule

// File: tb/tb_sel_decoder_seq.sv
//------------------------------------------------------------------------------
// tb_sel_decoder_seq
//
// Directed bench for sel_decoder_seq with N=3. u_dut uses DWELL=2, u_dut1
// shares the same inputs with DWELL=1 to cover the advance-every-cycle case.
//------------------------------------------------------------------------------
module tb_sel_decoder_seq;

    localparam int N = 3;
    localparam int M = 8;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           mode;
    logic           load_valid;
    logic [N-1:0]   load_sel;
    logic           stop;

    logic           load_ready;
    logic [M-1:0]   out;
    logic [N-1:0]   sel;
    logic           wrap;

    logic           load_ready1;
    logic [M-1:0]   out1;
    logic [N-1:0]   sel1;
    logic           wrap1;

    int checks   = 0;
    int failures = 0;

    sel_decoder_seq #(.N(N), .DWELL(2)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_mode       (mode),
        .i_load_valid (load_valid),
        .i_load_sel   (load_sel),
        .o_load_ready (load_ready),
        .i_stop       (stop),
        .o_out        (out),
        .o_sel        (sel),
        .o_wrap       (wrap)
    );

    sel_decoder_seq #(.N(N), .DWELL(1)) u_dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_mode       (mode),
        .i_load_valid (load_valid),
        .i_load_sel   (load_sel),
        .o_load_ready (load_ready1),
        .i_stop       (stop),
        .o_out        (out1),
        .o_sel        (sel1),
        .o_wrap       (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_out(input bit active, input int idx);
        logic [7:0] v;
        v = active ? (8'd1 << idx) : 8'd0;
`ifdef SEL_DECODER_ACTIVE_LOW_EN
        v = ~v;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_sel2 [8];
    logic       exp_wrp2 [8];

    initial begin
        exp_sel2 = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1, 3'd1};
        exp_wrp2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n      = 1'b0;
        en         = 1'b0;
        mode       = 1'b0;
        load_valid = 1'b0;
        load_sel   = '0;
        stop       = 1'b0;

        #2;
        chk("rst_out",   out,        exp_out(0, 0));
        chk("rst_sel",   sel,        8'd0);
        chk("rst_wrap",  wrap,       8'd0);
        chk("rst_ready", load_ready, 8'd1);
`ifdef SEL_DECODER_ACTIVE_LOW_EN
        chk("rst_out_ff", out, 8'hFF);
`endif

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // IDLE with enable high keeps the output inactive.
        en = 1'b1;
        tick();
        chk("idle_out", out, exp_out(0, 0));

        // Hold load of 5.
        load_valid = 1'b1;
        load_sel   = 3'd5;
        mode       = 1'b0;
        tick();
        load_valid = 1'b0;
`ifdef SEL_DECODER_ACTIVE_LOW_EN
        chk("hold5_out", out, 8'b1101_1111);
`else
        chk("hold5_out", out, 8'b0010_0000);
`endif
        chk("hold5_sel",   sel,        8'd5);
        chk("hold5_ready", load_ready, 8'd1);
        en = 1'b0;
        tick();
        chk("hold5_en0_out", out, exp_out(0, 0));
        chk("hold5_en0_sel", sel, 8'd5);
        en = 1'b1;
        tick();
        chk("hold5_en1_out", out, exp_out(1, 5));

        // Back-to-back hold loads 0..7.
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_sel   = 3'(i);
            tick();
            chk($sformatf("hold_ex_out%0d", i), out, exp_out(1, i));
            chk($sformatf("hold_ex_hot%0d", i),
                8'($onehot(out ^ exp_out(0, 0))), 8'd1);
        end
        load_valid = 1'b0;

        // Scan from 6. u_dut: each index for 2 cycles. u_dut1: every cycle.
        load_valid = 1'b1;
        load_sel   = 3'd6;
        mode       = 1'b1;
        tick();
        load_valid = 1'b0;
        mode       = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("scan_sel%0d", k),   sel,        8'(exp_sel2[k]));
            chk($sformatf("scan_wrap%0d", k),  wrap,       8'(exp_wrp2[k]));
            chk($sformatf("scan_ready%0d", k), load_ready, 8'd0);
            chk($sformatf("scan_out%0d", k),   out,        exp_out(1, int'(exp_sel2[k])));
            chk($sformatf("d1_sel%0d", k),     sel1,       8'((6 + k) % 8));
            chk($sformatf("d1_wrap%0d", k),    wrap1,      8'(k == 2));
            tick();
        end
        // u_dut now shows index 2 for its first dwell cycle.
        chk("scan_sel_pre_pause", sel, 8'd2);

        // Pause three cycles.
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("pause_out%0d", k),  out,  exp_out(0, 0));
            chk($sformatf("pause_sel%0d", k),  sel,  8'd2);
            chk($sformatf("pause_wrap%0d", k), wrap, 8'd0);
        end
        en = 1'b1;
        tick();
        chk("resume_sel_a", sel, 8'd2);
        chk("resume_out_a", out, exp_out(1, 2));
        tick();
        chk("resume_sel_b", sel, 8'd3);

        // Stop with a simultaneous load while scanning.
        stop       = 1'b1;
        load_valid = 1'b1;
        load_sel   = 3'd1;
        tick();
        stop       = 1'b0;
        load_valid = 1'b0;
        chk("stop_scan_out",   out,        exp_out(0, 0));
        chk("stop_scan_sel",   sel,        8'd3);
        chk("stop_scan_wrap",  wrap,       8'd0);
        chk("stop_scan_ready", load_ready, 8'd1);
        tick();
        chk("stop_scan_idle_out", out, exp_out(0, 0));

        // Stop wins over a load that would otherwise be accepted (HOLD).
        load_valid = 1'b1;
        load_sel   = 3'd4;
        tick();
        chk("hold4_out", out, exp_out(1, 4));
        stop     = 1'b1;
        load_sel = 3'd7;
        mode     = 1'b1;
        tick();
        stop       = 1'b0;
        load_valid = 1'b0;
        mode       = 1'b0;
        chk("stop_hold_out",   out,        exp_out(0, 0));
        chk("stop_hold_sel",   sel,        8'd4);
        chk("stop_hold_ready", load_ready, 8'd1);

        // Active-low/high hold of index 2.
        load_valid = 1'b1;
        load_sel   = 3'd2;
        tick();
        load_valid = 1'b0;
`ifdef SEL_DECODER_ACTIVE_LOW_EN
        chk("hold2_out", out, 8'b1111_1011);
`else
        chk("hold2_out", out, 8'b0000_0100);
`endif

        // Async reset right after a wrap, between clock edges.
        load_valid = 1'b1;
        load_sel   = 3'd7;
        mode       = 1'b1;
        tick();
        load_valid = 1'b0;
        mode       = 1'b0;
        tick();
        tick();
        chk("pre_rst_sel",  sel,  8'd0);
        chk("pre_rst_wrap", wrap, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out",   out,        exp_out(0, 0));
        chk("arst_sel",   sel,        8'd0);
        chk("arst_wrap",  wrap,       8'd0);
        chk("arst_ready", load_ready, 8'd1);
        chk("arst_sel1",  sel1,       8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_out", out, exp_out(0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sel_decoder_seq.md
# sel_decoder_seq

Registered, parametrised N-to-2^N one-hot decoder with a load handshake and an auto-scan mode, succeeding the fixed combinational 3-to-8 decoder. It either holds a loaded select value on its one-hot output or steps through all 2^N outputs with a programmable dwell time. It sits between control logic and per-channel strobes (e.g. display digit / row drive, channel polling).

## Interface
- `N`, 3, select width; output width is 2^N (derived, not a parameter); legal range 1..8
- `DWELL`, 1, cycles each output stays active in scan mode; legal range ≥1
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  output enable; 0 forces `out` inactive and freezes scan progress
- `mode`  in  1  sampled only on load accept: 0 = hold, 1 = scan
- `load_valid`  in  1  load request
- `load_sel`  in  N  select value / scan start index
- `load_ready`  out  1  block can accept a load
- `stop`  in  1  abort scan / clear hold, return to IDLE
- `out`  out  2^N  registered one-hot output
- `sel`  out  N  current select index
- `wrap`  out  1  one-cycle pulse when scan steps from 2^N-1 to 0

## Operation
- States: IDLE, HOLD, SCAN. Reset -> IDLE, `out`=0, `sel`=0, `wrap`=0, `load_ready`=1, dwell counter=0.
- Load accept = `load_valid & load_ready` at a rising edge: `sel`<=`load_sel`, dwell counter<=0; `mode`=0 -> HOLD, `mode`=1 -> SCAN.
- `load_ready` = 1 in IDLE and HOLD, 0 in SCAN.
- IDLE: `out`=0.
- HOLD: `out` = one-hot(`sel`) when `en`=1, else 0; `sel` retained. A new load in HOLD replaces `sel` (and may switch to SCAN).
- SCAN: `out` = one-hot(`sel`) when `en`=1. Dwell counter increments each `en`=1 cycle; when it reaches DWELL-1 it clears and `sel` <= `sel`+1 modulo 2^N. `wrap` asserts for exactly the cycle after `sel` goes 2^N-1 -> 0 (registered with `sel`).
- `en`=0 in SCAN: `out`=0, dwell counter and `sel` frozen, `wrap`=0; scan resumes at the same point when `en` returns.
- `stop`=1 at any edge -> IDLE, `out`=0, `sel` retained, `wrap`=0. `stop` has priority over a simultaneous load (load not accepted, `load_ready` already sampled as 1 is ignored).
- `out` is never multi-hot; only one bit (or none) asserted in any cycle.
- Asynchronous reset mid-scan immediately clears all outputs to reset values, independent of `clk`.

## Timing
- All outputs registered; no combinational path from inputs to `out`, `sel`, `wrap`.
- Load accepted at edge k -> `out`/`sel` reflect `load_sel` after edge k (visible cycle k+1); latency 1.
- `en` change at edge k -> `out` updates after edge k.
- SCAN with DWELL=D, `en` held 1: each index is active for exactly D consecutive cycles; full sweep = D*2^N cycles.
- DWELL=1: `sel` advances every cycle.
- `stop` at edge k -> `out`=0 after edge k; `load_ready`=1 from cycle k+1.

## Configuration
- `SEL_DECODER_ACTIVE_LOW_EN`: defined -> `out` is one-cold (active bit 0, inactive bits 1); reset and IDLE/`en`=0 value all ones. Undefined -> active-high one-hot, inactive value all zeros. `sel`, `wrap`, `load_ready` unaffected.

## Test plan
- Reset/hold, N=3: release `rst_n`, load `load_sel`=5, `mode`=0 -> `out`=8'b0010_0000 from next cycle, `load_ready`=1; drop `en` -> `out`=0, `sel`=5.
- Exhaustive hold: load 0..7 in successive cycles -> `out` = 1<<i one cycle after each load, never multi-hot.
- Scan, N=3, DWELL=2: load 6, `mode`=1 -> `sel` sequence 6,6,7,7,0,0,1..., `wrap`=1 only in the first cycle `sel`=0, `load_ready`=0 throughout.
- Pause/abort: during scan, `en`=0 for 3 cycles -> `out`=0, `sel` frozen, resumes with remaining dwell; then `stop` with simultaneous `load_valid` -> IDLE, `out`=0, load ignored, `load_ready`=1 next cycle.
- Async reset mid-scan: assert `rst_n`=0 between edges -> `out`=0, `sel`=0, `wrap`=0 immediately.
- With `SEL_DECODER_ACTIVE_LOW_EN`: hold load 2 -> `out`=8'b1111_1011; reset value 8'hFF.
